// File: rtl/softmax_pkg.sv
// Shared definitions for the pipelined softmax datapath: operand width,
// multiplier latency and the feeder's state encoding.
package softmax_pkg;

  localparam int DATA_W = 32;
  // Must match the pipeline depth configured in multiplier1.
  localparam int MUL_LAT = 3;
  localparam logic [31:0] FP_ONE = 32'h3F800000;

  typedef logic [1:0] state_t;

  localparam state_t ST_FILL       = 2'd0;
  localparam state_t ST_WAIT_RECIP = 2'd1;
  localparam state_t ST_REPLAY     = 2'd2;

endpackage

// File: rtl/valid_delay_line.sv
// Fixed-depth shift register carrying {valid, last} alongside a pipelined
// datapath so the sideband lines up with the pipeline's output.
module valid_delay_line #(
  parameter int DEPTH = 3
) (
  input  logic clk,
  input  logic areset,
  input  logic in_valid,
  input  logic in_last,
  output logic out_valid,
  output logic out_last
);

  logic [DEPTH-1:0] valid_reg;
  logic [DEPTH-1:0] last_reg;

  always_ff @(posedge clk) begin
    if (areset) begin
      valid_reg <= '0;
      last_reg  <= '0;
    end else begin
      valid_reg[0] <= in_valid;
      last_reg[0]  <= in_valid & in_last;
      for (int i = 1; i < DEPTH; i++) begin
        valid_reg[i] <= valid_reg[i-1];
        last_reg[i]  <= last_reg[i-1];
      end
    end
  end

  assign out_valid = valid_reg[DEPTH-1];
  assign out_last  = last_reg[DEPTH-1];

endmodule

// File: rtl/softmax_norm_feeder.sv
// Buffers one vector of exponentials, then replays each element paired with
// the latched reciprocal into multiplier1, with q_valid/q_last aligned to it.
module softmax_norm_feeder #(
  parameter int DATA_W  = softmax_pkg::DATA_W,
  parameter int VEC_LEN = 16,
  parameter int MUL_LAT = softmax_pkg::MUL_LAT
) (
  input  logic              clk,
  input  logic              areset,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              in_ready,
  input  logic              recip_valid,
  input  logic [DATA_W-1:0] recip_data,
  output logic [DATA_W-1:0] mul_a,
  output logic [DATA_W-1:0] mul_b,
  output logic              mul_valid,
  output logic              q_valid,
  output logic              q_last,
  output logic              err_trunc,
  output logic              err_recip
);

  import softmax_pkg::*;

  localparam int CNT_W = $clog2(VEC_LEN + 1);
  localparam int IDX_W = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;

  state_t            state_reg;
  logic [DATA_W-1:0] mem [VEC_LEN];
  logic [CNT_W-1:0]  wr_cnt_reg;
  logic [CNT_W-1:0]  rd_cnt_reg;
  logic [CNT_W-1:0]  len_reg;
  logic [DATA_W-1:0] recip_reg;
  logic [DATA_W-1:0] mul_a_reg;
  logic [DATA_W-1:0] mul_b_reg;
  logic              mul_valid_reg;
  logic              mul_last_reg;
  logic              err_trunc_reg;
  logic              err_recip_reg;

  logic accept;
  logic at_cap;
  logic issue_last;

  assign in_ready   = (state_reg == ST_FILL) && !areset;
  assign accept     = in_valid && in_ready;
  assign at_cap     = (wr_cnt_reg == CNT_W'(VEC_LEN - 1));
  assign issue_last = (rd_cnt_reg == len_reg - CNT_W'(1));

  // Buffer contents survive reset untouched; only the counters define validity.
  always_ff @(posedge clk) begin
    if (accept) begin
      mem[wr_cnt_reg[IDX_W-1:0]] <= in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (areset) begin
      state_reg     <= ST_FILL;
      wr_cnt_reg    <= '0;
      rd_cnt_reg    <= '0;
      len_reg       <= '0;
      recip_reg     <= '0;
      mul_a_reg     <= '0;
      mul_b_reg     <= '0;
      mul_valid_reg <= 1'b0;
      mul_last_reg  <= 1'b0;
      err_trunc_reg <= 1'b0;
      err_recip_reg <= 1'b0;
    end else begin
      mul_valid_reg <= 1'b0;
      mul_last_reg  <= 1'b0;
      if (recip_valid && (state_reg != ST_WAIT_RECIP)) begin
        err_recip_reg <= 1'b1;
      end
      case (state_reg)
        ST_FILL: begin
          if (accept) begin
            wr_cnt_reg <= wr_cnt_reg + CNT_W'(1);
            // A full buffer closes the vector; the extra element stays upstream.
            if (in_last || at_cap) begin
              len_reg   <= wr_cnt_reg + CNT_W'(1);
              state_reg <= ST_WAIT_RECIP;
              if (!in_last) begin
                err_trunc_reg <= 1'b1;
              end
            end
          end
        end
        ST_WAIT_RECIP: begin
          if (recip_valid) begin
            recip_reg  <= recip_data;
            rd_cnt_reg <= '0;
            state_reg  <= ST_REPLAY;
          end
        end
        ST_REPLAY: begin
          mul_a_reg     <= mem[rd_cnt_reg[IDX_W-1:0]];
          mul_b_reg     <= recip_reg;
          mul_valid_reg <= 1'b1;
          mul_last_reg  <= issue_last;
          rd_cnt_reg    <= rd_cnt_reg + CNT_W'(1);
          if (issue_last) begin
            state_reg  <= ST_FILL;
            wr_cnt_reg <= '0;
          end
        end
        default: state_reg <= ST_FILL;
      endcase
    end
  end

  valid_delay_line #(
    .DEPTH (MUL_LAT)
  ) u_q_delay (
    .clk       (clk),
    .areset    (areset),
    .in_valid  (mul_valid_reg),
    .in_last   (mul_last_reg),
    .out_valid (q_valid),
    .out_last  (q_last)
  );

  assign mul_a     = mul_a_reg;
  assign mul_b     = mul_b_reg;
  assign mul_valid = mul_valid_reg;
  assign err_trunc = err_trunc_reg;
  assign err_recip = err_recip_reg;

endmodule

// File: tb/tb_softmax_norm_feeder.sv
// Directed-plus-random bench for softmax_norm_feeder: expected multiplier
// pairs and q timing come from a per-vector model of the replay schedule.
module tb_softmax_norm_feeder;

  localparam int DATA_W  = 32;
  localparam int VEC_LEN = 16;
  localparam int MUL_LAT = 3;

  logic              clk = 1'b0;
  logic              areset = 1'b1;
  logic              in_valid = 1'b0;
  logic [DATA_W-1:0] in_data = '0;
  logic              in_last = 1'b0;
  logic              in_ready;
  logic              recip_valid = 1'b0;
  logic [DATA_W-1:0] recip_data = '0;
  logic [DATA_W-1:0] mul_a;
  logic [DATA_W-1:0] mul_b;
  logic              mul_valid;
  logic              q_valid;
  logic              q_last;
  logic              err_trunc;
  logic              err_recip;

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;

  // Observed events (monitor) and expected events (model)
  int          mon_mul_cyc[$];
  logic [31:0] mon_a[$];
  logic [31:0] mon_b[$];
  int          mon_q_cyc[$];
  logic        mon_q_last[$];
  int          exp_mul_cyc[$];
  logic [31:0] exp_a[$];
  logic [31:0] exp_b[$];
  int          exp_q_cyc[$];
  logic        exp_q_last[$];
  logic [31:0] vec_q[$];

  softmax_norm_feeder #(
    .DATA_W  (DATA_W),
    .VEC_LEN (VEC_LEN),
    .MUL_LAT (MUL_LAT)
  ) dut (
    .clk         (clk),
    .areset      (areset),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_last     (in_last),
    .in_ready    (in_ready),
    .recip_valid (recip_valid),
    .recip_data  (recip_data),
    .mul_a       (mul_a),
    .mul_b       (mul_b),
    .mul_valid   (mul_valid),
    .q_valid     (q_valid),
    .q_last      (q_last),
    .err_trunc   (err_trunc),
    .err_recip   (err_recip)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (mul_valid) begin
      mon_mul_cyc.push_back(cyc);
      mon_a.push_back(mul_a);
      mon_b.push_back(mul_b);
    end
    if (q_valid) begin
      mon_q_cyc.push_back(cyc);
      mon_q_last.push_back(q_last);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    compared++;
    assert (obs === expv) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (!in_ready && n < 200) begin
      tick();
      n++;
    end
    chk({tag, "_ready"}, 32'(in_ready), 32'd1);
  endtask

  task automatic send_words(input int n, input bit last_on_final, input bit recip_on_final);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_data  = vec_q[i];
      in_last  = last_on_final && (i == n - 1);
      wait_ready("send");
      recip_valid = recip_on_final && (i == n - 1);
      recip_data  = 32'h3F800000;
      tick();
      recip_valid = 1'b0;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic pulse_recip(input logic [31:0] v, output int r);
    recip_valid = 1'b1;
    recip_data  = v;
    tick();
    r = cyc;
    recip_valid = 1'b0;
  endtask

  task automatic fill_random(input int n);
    vec_q.delete();
    for (int i = 0; i < n; i++) vec_q.push_back($urandom);
  endtask

  // Reciprocal sampled at edge r: pair i leaves at r+1+i, its product at +MUL_LAT.
  function automatic void model_vector(input int len, input logic [31:0] rc, input int r);
    for (int i = 0; i < len; i++) begin
      exp_mul_cyc.push_back(r + 1 + i);
      exp_a.push_back(vec_q[i]);
      exp_b.push_back(rc);
      exp_q_cyc.push_back(r + 1 + i + MUL_LAT);
      exp_q_last.push_back(i == len - 1);
    end
  endfunction

  task automatic verify(input string tag);
    repeat (VEC_LEN + MUL_LAT + 4) tick();
    chk({tag, "_mul_count"}, 32'(mon_mul_cyc.size()), 32'(exp_mul_cyc.size()));
    for (int i = 0; i < exp_mul_cyc.size() && i < mon_mul_cyc.size(); i++) begin
      chk($sformatf("%s_mul_cyc[%0d]", tag, i), 32'(mon_mul_cyc[i]), 32'(exp_mul_cyc[i]));
      chk($sformatf("%s_mul_a[%0d]", tag, i), mon_a[i], exp_a[i]);
      chk($sformatf("%s_mul_b[%0d]", tag, i), mon_b[i], exp_b[i]);
    end
    chk({tag, "_q_count"}, 32'(mon_q_cyc.size()), 32'(exp_q_cyc.size()));
    for (int i = 0; i < exp_q_cyc.size() && i < mon_q_cyc.size(); i++) begin
      chk($sformatf("%s_q_cyc[%0d]", tag, i), 32'(mon_q_cyc[i]), 32'(exp_q_cyc[i]));
      chk($sformatf("%s_q_last[%0d]", tag, i), 32'(mon_q_last[i]), 32'(exp_q_last[i]));
    end
    $display("vector %s: %0d pairs, %0d products checked", tag, mon_mul_cyc.size(), mon_q_cyc.size());
    mon_mul_cyc.delete(); mon_a.delete(); mon_b.delete(); mon_q_cyc.delete(); mon_q_last.delete();
    exp_mul_cyc.delete(); exp_a.delete(); exp_b.delete(); exp_q_cyc.delete(); exp_q_last.delete();
  endtask

  initial begin
    int          r;
    int          r2;
    int          len;
    logic [31:0] rc;
    logic [31:0] held;

    // Reset values
    areset = 1'b1;
    repeat (3) tick();
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_mul_valid", 32'(mul_valid), 32'd0);
    chk("rst_mul_a", mul_a, 32'd0);
    chk("rst_mul_b", mul_b, 32'd0);
    chk("rst_q_valid", 32'(q_valid), 32'd0);
    chk("rst_q_last", 32'(q_last), 32'd0);
    chk("rst_err_trunc", 32'(err_trunc), 32'd0);
    chk("rst_err_recip", 32'(err_recip), 32'd0);
    areset = 1'b0;
    #1;
    chk("rel_in_ready", 32'(in_ready), 32'd1);
    tick();

    // Basic 4-element vector, reciprocal one cycle after in_last
    vec_q = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000};
    send_words(4, 1'b1, 1'b0);
    chk("t1_wait_in_ready", 32'(in_ready), 32'd0);
    pulse_recip(32'h3DCCCCCD, r);
    model_vector(4, 32'h3DCCCCCD, r);
    verify("t1");

    // 17 elements without in_last: truncation and stalled 17th element
    fill_random(17);
    send_words(16, 1'b0, 1'b0);
    chk("t2_in_ready_full", 32'(in_ready), 32'd0);
    chk("t2_err_trunc", 32'(err_trunc), 32'd1);
    chk("t2_err_recip", 32'(err_recip), 32'd0);
    held = vec_q[16];
    in_valid = 1'b1;
    in_data  = held;
    in_last  = 1'b1;
    rc = $urandom;
    pulse_recip(rc, r);
    model_vector(16, rc, r);
    wait_ready("t2_hold");
    chk("t2_accept_edge", 32'(cyc + 1), 32'(r + 17));
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
    verify("t2");
    vec_q = '{held};
    rc = $urandom;
    pulse_recip(rc, r);
    model_vector(1, rc, r);
    verify("t2_held");

    // Reciprocal outside WAIT_RECIP is ignored and flagged
    pulse_recip($urandom, r);
    repeat (4) tick();
    chk("t3_err_recip", 32'(err_recip), 32'd1);
    fill_random(3);
    send_words(3, 1'b1, 1'b1);
    repeat (3) tick();
    chk("t3_no_replay", 32'(mon_mul_cyc.size()), 32'd0);
    rc = $urandom;
    pulse_recip(rc, r);
    model_vector(3, rc, r);
    verify("t3");

    // Reset on the second replay edge kills the vector
    fill_random(4);
    send_words(4, 1'b1, 1'b0);
    rc = $urandom;
    pulse_recip(rc, r);
    tick();
    areset = 1'b1;
    tick();
    chk("t4_mul_valid", 32'(mul_valid), 32'd0);
    chk("t4_in_ready_rst", 32'(in_ready), 32'd0);
    chk("t4_err_trunc", 32'(err_trunc), 32'd0);
    chk("t4_err_recip", 32'(err_recip), 32'd0);
    areset = 1'b0;
    #1;
    chk("t4_in_ready_rel", 32'(in_ready), 32'd1);
    exp_mul_cyc.push_back(r + 1);
    exp_a.push_back(vec_q[0]);
    exp_b.push_back(rc);
    verify("t4");

    // Single-element vector
    fill_random(1);
    send_words(1, 1'b1, 1'b0);
    pulse_recip(32'h3F800000, r);
    model_vector(1, 32'h3F800000, r);
    verify("t5");

    // Back-to-back vectors with distinct reciprocals
    fill_random(3);
    send_words(3, 1'b1, 1'b0);
    pulse_recip(32'h3F000000, r);
    model_vector(3, 32'h3F000000, r);
    fill_random(2);
    send_words(2, 1'b1, 1'b0);
    pulse_recip(32'h3E800000, r2);
    model_vector(2, 32'h3E800000, r2);
    verify("t6");

    // Random vectors with random divider wait
    for (int k = 0; k < 8; k++) begin
      len = $urandom_range(1, VEC_LEN);
      fill_random(len);
      send_words(len, 1'b1, 1'b0);
      repeat ($urandom_range(0, 3)) tick();
      rc = $urandom;
      pulse_recip(rc, r);
      model_vector(len, rc, r);
      verify($sformatf("rnd%0d", k));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
